// File: rtl/system_flit_generator_pkg.sv
// Shared types for the system-flit transmit path: node ids, flit layout,
// routing states and the output-side generator state.
package system_flit_generator_pkg;

  typedef logic [7:0] node_id_t;

  localparam node_id_t BROADCAST_NODE_ID = 8'hFF;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    SYSTEM = 2'd1
  } flittype_t;

  typedef enum logic [3:0] {
    ROUTING_IDLE            = 4'd0,
    I_WAIT_PARENT_ACK       = 4'd1,
    I_GENERATE_JOIN_REQUEST = 4'd2,
    I_WAIT_JOIN_ACK         = 4'd3,
    S_WAIT_PARENT_ACK       = 4'd4,
    S_GENERATE_JOIN_REQUEST = 4'd5,
    S_WAIT_JOIN_ACK         = 4'd6,
    NORMAL                  = 4'd7,
    FATAL_ERROR             = 4'd8
  } routing_state_t;

  typedef enum logic [2:0] {
    S_PARENT_REQUEST = 3'd0,
    S_PARENT_ACK     = 3'd1,
    S_JOIN_REQUEST   = 3'd2,
    S_JOIN_ACK       = 3'd3,
    S_HEARTBEAT      = 3'd4
  } system_flit_type_t;

  typedef struct packed {
    system_flit_type_t sys_type;
    logic              is_init;
    logic [3:0]        rsvd;
  } system_header_t;

  typedef struct packed {
    node_id_t   child_id;
    logic [7:0] rsvd;
  } system_payload_t;

  typedef struct packed {
    flittype_t flittype;
    node_id_t  src_id;
    node_id_t  dst_id;
  } header_t;

  typedef struct packed {
    header_t         header;
    system_header_t  sys_header;
    system_payload_t payload;
  } flit_t;

  typedef enum logic {
    G_IDLE = 1'b0,
    G_SEND = 1'b1
  } gen_state_t;

  function automatic logic is_init_state(input routing_state_t s);
    return (s == I_WAIT_PARENT_ACK) || (s == I_GENERATE_JOIN_REQUEST) ||
           (s == I_WAIT_JOIN_ACK);
  endfunction

endpackage

// File: rtl/system_flit_retry_timer.sv
// Free-running period timer: counts while enabled, pulses expire on the
// last count of the period, and restarts from zero on clear or expiry.
module system_flit_retry_timer #(
  parameter int unsigned PERIOD = 1024
) (
  input  logic nocclk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned W = $clog2(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] count_q, count_d;

  assign expire = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear || expire) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/system_flit_generator.sv
// Builds SYSTEM flits for the routing/join protocol: decode-path replies plus
// self-generated parent requests, join requests, retries and heartbeats.
module system_flit_generator
  import system_flit_generator_pkg::*;
#(
  parameter bit          IS_ROOT          = 1'b0,
  parameter int unsigned RETRY_CYCLES     = 1024,
  parameter int unsigned MAX_RETRIES      = 8,
  parameter int unsigned HEARTBEAT_CYCLES = 4096
) (
  input  logic            nocclk,
  input  logic            rst_n,
  input  routing_state_t  routing_state,
  input  node_id_t        this_node_id,
  input  node_id_t        parent_id,
  input  logic            reply_valid,
  output logic            reply_ready,
  input  system_header_t  reply_header,
  input  system_payload_t reply_payload,
  input  node_id_t        reply_dst_id,
  output flit_t           flit_out,
  output logic            flit_out_valid,
  input  logic            flit_out_ready,
  output logic            update_next_state,
  output routing_state_t  next_routing_state
);

  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] MAX_CNT = RW'(MAX_RETRIES);

  gen_state_t     gen_q, gen_d;
  routing_state_t prev_state_q;
  flit_t          flit_q, flit_d, self_flit, reply_flit;
  logic           pend_q, pend_d, inflight_q, inflight_d, is_gen_q, is_gen_d;
  logic [RW-1:0]  retry_cnt_q, retry_cnt_d;
  logic           upd_q, upd_d;
  routing_state_t next_state_q, next_state_d;

  logic in_wait_pa, in_gen, in_wait_ja, in_normal, entry, pend_eff;
  logic load_reply, load_self, hs, self_hs, timer_en, tmr_clear;
  logic retry_exp, hb_exp, retry_fire, retry_fatal;

  assign in_wait_pa = (routing_state == I_WAIT_PARENT_ACK) || (routing_state == S_WAIT_PARENT_ACK);
  assign in_gen     = (routing_state == I_GENERATE_JOIN_REQUEST) ||
                      (routing_state == S_GENERATE_JOIN_REQUEST);
  assign in_wait_ja = (routing_state == I_WAIT_JOIN_ACK) || (routing_state == S_WAIT_JOIN_ACK);
  assign in_normal  = (routing_state == NORMAL);

  // Entry replaces whatever was pending: an unloaded flit of the old state is dropped.
  assign entry    = (routing_state != prev_state_q);
  assign pend_eff = entry ? (!IS_ROOT && (in_wait_pa || in_gen)) : pend_q;

  // Handshake: a reply moves on reply_valid && reply_ready, a flit moves on
  // flit_out_valid && flit_out_ready; flit_out holds steady while valid && !ready.
  assign load_reply = reply_ready && reply_valid;
  assign load_self  = (gen_q == G_IDLE) && !reply_valid && pend_eff;
  assign hs         = (gen_q == G_SEND) && flit_out_ready;
  assign self_hs    = hs && inflight_q;

  assign timer_en    = !IS_ROOT && !pend_eff && !inflight_q;
  assign tmr_clear   = entry || self_hs;
  assign retry_fire  = retry_exp && (retry_cnt_q != MAX_CNT);
  assign retry_fatal = retry_exp && (retry_cnt_q == MAX_CNT);

  system_flit_retry_timer #(.PERIOD(RETRY_CYCLES)) u_retry_timer (
    .nocclk (nocclk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (timer_en && (in_wait_pa || in_wait_ja)),
    .expire (retry_exp)
  );

  system_flit_retry_timer #(.PERIOD(HEARTBEAT_CYCLES)) u_heartbeat_timer (
    .nocclk (nocclk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (timer_en && in_normal),
    .expire (hb_exp)
  );

  always_comb begin
    self_flit                    = '0;
    self_flit.header.flittype    = SYSTEM;
    self_flit.header.src_id      = this_node_id;
    self_flit.header.dst_id      = parent_id;
    self_flit.sys_header.is_init = is_init_state(routing_state);
    if (in_wait_pa) begin
      self_flit.sys_header.sys_type = S_PARENT_REQUEST;
      self_flit.header.dst_id       = BROADCAST_NODE_ID;
    end else if (in_gen || in_wait_ja) begin
      self_flit.sys_header.sys_type = S_JOIN_REQUEST;
      self_flit.payload.child_id    = this_node_id;
    end else begin
      self_flit.sys_header.sys_type = S_HEARTBEAT;
    end
  end

  always_comb begin
    reply_flit.header.flittype = SYSTEM;
    reply_flit.header.src_id   = this_node_id;
    reply_flit.header.dst_id   = reply_dst_id;
    reply_flit.sys_header      = reply_header;
    reply_flit.payload         = reply_payload;
  end

  always_comb begin
    flit_d      = flit_q;
    inflight_d  = inflight_q;
    is_gen_d    = is_gen_q;
    retry_cnt_d = retry_cnt_q;
    if (load_reply) begin
      flit_d     = reply_flit;
      inflight_d = 1'b0;
      is_gen_d   = 1'b0;
    end else if (load_self) begin
      flit_d     = self_flit;
      inflight_d = 1'b1;
      is_gen_d   = in_gen;
    end else if (hs) begin
      inflight_d = 1'b0;
    end
    pend_d = (pend_eff && !load_self) || retry_fire || hb_exp;
    if (entry) begin
      retry_cnt_d = '0;
    end else if (retry_fire) begin
      retry_cnt_d = retry_cnt_q + 1'b1;
    end
    upd_d        = 1'b0;
    next_state_d = FATAL_ERROR;
    if (self_hs && is_gen_q && in_gen) begin
      upd_d        = 1'b1;
      next_state_d = (routing_state == I_GENERATE_JOIN_REQUEST) ? I_WAIT_JOIN_ACK : S_WAIT_JOIN_ACK;
    end else if (retry_fatal) begin
      upd_d = 1'b1;
    end
  end

  // Output FSM: state register
  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      gen_q <= G_IDLE;
    end else begin
      gen_q <= gen_d;
    end
  end

  // Output FSM: next state
  always_comb begin
    gen_d = gen_q;
    if (gen_q == G_IDLE) begin
      if (load_reply || load_self) begin
        gen_d = G_SEND;
      end
    end else if (flit_out_ready) begin
      gen_d = G_IDLE;
    end
  end

  // Output FSM: outputs
  always_comb begin
    flit_out_valid = (gen_q == G_SEND);
    reply_ready    = rst_n && (gen_q == G_IDLE);
  end

  always_ff @(posedge nocclk) begin
    if (!rst_n) begin
      prev_state_q <= FATAL_ERROR;
      flit_q       <= '0;
      pend_q       <= 1'b0;
      inflight_q   <= 1'b0;
      is_gen_q     <= 1'b0;
      retry_cnt_q  <= '0;
      upd_q        <= 1'b0;
      next_state_q <= FATAL_ERROR;
    end else begin
      prev_state_q <= routing_state;
      flit_q       <= flit_d;
      pend_q       <= pend_d;
      inflight_q   <= inflight_d;
      is_gen_q     <= is_gen_d;
      retry_cnt_q  <= retry_cnt_d;
      upd_q        <= upd_d;
      next_state_q <= next_state_d;
    end
  end

  assign flit_out           = flit_q;
  assign update_next_state  = upd_q;
  assign next_routing_state = next_state_q;

endmodule

// File: tb/tb_system_flit_generator.sv
// Directed bench for system_flit_generator: retries, join stall, reply
// priority, heartbeats, state-change drop, mid-flight reset and root node.
module tb_system_flit_generator;
  import system_flit_generator_pkg::*;

  localparam int RETRY = 10;
  localparam int MAXR  = 8;
  localparam int HB    = 16;
  localparam int FW    = $bits(flit_t);
  localparam node_id_t NODE   = 8'h23;
  localparam node_id_t PARENT = 8'h10;

  logic            nocclk = 1'b0;
  logic            rst_n;
  routing_state_t  routing_state;
  node_id_t        this_node_id, parent_id, reply_dst_id;
  logic            reply_valid, reply_ready, flit_out_ready;
  system_header_t  reply_header;
  system_payload_t reply_payload;
  flit_t           flit_out;
  logic            flit_out_valid, update_next_state;
  routing_state_t  next_routing_state;

  logic            root_reply_valid = 1'b0;
  logic            root_ready_in    = 1'b1;
  logic            root_reply_ready, root_valid, root_upd;
  flit_t           root_flit;
  routing_state_t  root_next;

  int checks = 0;
  int passed = 0;
  int root_valid_seen = 0;
  int root_upd_seen = 0;
  logic [FW-1:0] exp_q[$];

  always #5 nocclk = ~nocclk;

  system_flit_generator #(
    .IS_ROOT(1'b0), .RETRY_CYCLES(RETRY), .MAX_RETRIES(MAXR), .HEARTBEAT_CYCLES(HB)
  ) dut (
    .nocclk(nocclk), .rst_n(rst_n), .routing_state(routing_state),
    .this_node_id(this_node_id), .parent_id(parent_id),
    .reply_valid(reply_valid), .reply_ready(reply_ready),
    .reply_header(reply_header), .reply_payload(reply_payload), .reply_dst_id(reply_dst_id),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_out_ready(flit_out_ready),
    .update_next_state(update_next_state), .next_routing_state(next_routing_state)
  );

  system_flit_generator #(
    .IS_ROOT(1'b1), .RETRY_CYCLES(RETRY), .MAX_RETRIES(MAXR), .HEARTBEAT_CYCLES(HB)
  ) root_dut (
    .nocclk(nocclk), .rst_n(rst_n), .routing_state(routing_state),
    .this_node_id(this_node_id), .parent_id(parent_id),
    .reply_valid(root_reply_valid), .reply_ready(root_reply_ready),
    .reply_header(reply_header), .reply_payload(reply_payload), .reply_dst_id(reply_dst_id),
    .flit_out(root_flit), .flit_out_valid(root_valid), .flit_out_ready(root_ready_in),
    .update_next_state(root_upd), .next_routing_state(root_next)
  );

  always @(posedge nocclk) begin
    if (rst_n && root_valid) root_valid_seen++;
    if (rst_n && root_upd) root_upd_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge nocclk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (flit_out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic flit_t mk_flit(input system_flit_type_t t, input node_id_t dst,
                                    input node_id_t child, input logic init);
    flit_t f;
    f = '0;
    f.header.flittype    = SYSTEM;
    f.header.src_id      = NODE;
    f.header.dst_id      = dst;
    f.sys_header.sys_type = t;
    f.sys_header.is_init = init;
    f.payload.child_id   = child;
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; routing_state = FATAL_ERROR; this_node_id = NODE; parent_id = PARENT;
    reply_valid = 1'b0; reply_header = '0; reply_payload = '0; reply_dst_id = '0;
    flit_out_ready = 1'b1;
    tick(); tick();
    checks++; if (flit_out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", flit_out_valid); else passed++;
    checks++; if (flit_out !== flit_t'('0)) $display("FAIL reset_flit: got %h want 0", flit_out); else passed++;
    checks++; if (update_next_state !== 1'b0) $display("FAIL reset_upd: got %b want 0", update_next_state); else passed++;
    checks++; if (next_routing_state !== FATAL_ERROR) $display("FAIL reset_next: got %0d want %0d", next_routing_state, FATAL_ERROR); else passed++;
    checks++; if (reply_ready !== 1'b0) $display("FAIL reset_reply_ready: got %b want 0", reply_ready); else passed++;
  endtask

  task automatic test_parent_request();
    flit_t exp;
    int n, vcnt, ucnt;
    exp = mk_flit(S_PARENT_REQUEST, BROADCAST_NODE_ID, 8'h00, 1'b1);
    routing_state = I_WAIT_PARENT_ACK; rst_n = 1'b1;
    tick();
    checks++; if (flit_out_valid !== 1'b1) $display("FAIL preq_first_valid: got %b want 1", flit_out_valid); else passed++;
    checks++; if (flit_out !== exp) $display("FAIL preq_first_flit: got %h want %h", flit_out, exp); else passed++;
    for (int r = 1; r <= MAXR; r++) begin
      wait_valid(RETRY + 10, n);
      checks++; if (n != RETRY + 2) $display("FAIL preq_retry%0d_gap: got %0d want %0d", r, n, RETRY + 2); else passed++;
      checks++; if (flit_out !== exp) $display("FAIL preq_retry%0d_flit: got %h want %h", r, flit_out, exp); else passed++;
    end
    n = -1; vcnt = 0;
    for (int i = 1; i <= RETRY + 10; i++) begin
      tick();
      if (flit_out_valid) vcnt++;
      if (update_next_state) begin
        n = i;
        break;
      end
    end
    checks++; if (n != RETRY + 1) $display("FAIL fatal_pulse_gap: got %0d want %0d", n, RETRY + 1); else passed++;
    checks++; if (next_routing_state !== FATAL_ERROR) $display("FAIL fatal_next: got %0d want %0d", next_routing_state, FATAL_ERROR); else passed++;
    checks++; if (vcnt != 0) $display("FAIL fatal_no_flit: got %0d flits want 0", vcnt); else passed++;
    tick();
    checks++; if (update_next_state !== 1'b0) $display("FAIL fatal_pulse_width: got %b want 0", update_next_state); else passed++;
    routing_state = FATAL_ERROR;
    vcnt = 0; ucnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (flit_out_valid) vcnt++;
      if (update_next_state) ucnt++;
    end
    checks++; if (vcnt + ucnt != 0) $display("FAIL fatal_quiet: got %0d flits %0d pulses want 0", vcnt, ucnt); else passed++;
  endtask

  task automatic test_join_stall();
    flit_t exp;
    int n;
    exp = mk_flit(S_JOIN_REQUEST, PARENT, NODE, 1'b1);
    flit_out_ready = 1'b0;
    routing_state = I_GENERATE_JOIN_REQUEST;
    tick();
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== exp) $display("FAIL join_first: got v=%b %h want v=1 %h", flit_out_valid, flit_out, exp); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (flit_out_valid !== 1'b1 || flit_out !== exp) $display("FAIL join_stall%0d: got v=%b %h want v=1 %h", i, flit_out_valid, flit_out, exp); else passed++;
    end
    flit_out_ready = 1'b1;
    tick();
    checks++; if (update_next_state !== 1'b1) $display("FAIL join_upd: got %b want 1", update_next_state); else passed++;
    checks++; if (next_routing_state !== I_WAIT_JOIN_ACK) $display("FAIL join_next: got %0d want %0d", next_routing_state, I_WAIT_JOIN_ACK); else passed++;
    checks++; if (flit_out_valid !== 1'b0) $display("FAIL join_done_valid: got %b want 0", flit_out_valid); else passed++;
    routing_state = I_WAIT_JOIN_ACK;
    tick();
    checks++; if (update_next_state !== 1'b0 || next_routing_state !== FATAL_ERROR) $display("FAIL join_upd_end: got %b/%0d want 0/%0d", update_next_state, next_routing_state, FATAL_ERROR); else passed++;
    wait_valid(RETRY + 10, n);
    checks++; if (n != RETRY + 1) $display("FAIL join_retry_gap: got %0d want %0d", n, RETRY + 1); else passed++;
    checks++; if (flit_out !== exp) $display("FAIL join_retry_flit: got %h want %h", flit_out, exp); else passed++;
  endtask

  task automatic test_heartbeat();
    flit_t exp;
    int n;
    exp = mk_flit(S_HEARTBEAT, PARENT, 8'h00, 1'b0);
    routing_state = NORMAL;
    for (int k = 0; k < 3; k++) begin
      wait_valid(HB + 10, n);
      checks++; if (n != HB + 2) $display("FAIL hb%0d_gap: got %0d want %0d", k, n, HB + 2); else passed++;
      checks++; if (flit_out !== exp) $display("FAIL hb%0d_flit: got %h want %h", k, flit_out, exp); else passed++;
    end
  endtask

  task automatic test_reply_priority();
    flit_t r, exp;
    r = '0;
    r.header.flittype = SYSTEM; r.header.src_id = NODE; r.header.dst_id = 8'h05;
    r.sys_header.sys_type = S_JOIN_ACK; r.payload.child_id = 8'h42;
    exp_q.push_back(r);
    exp_q.push_back(mk_flit(S_HEARTBEAT, PARENT, 8'h00, 1'b0));
    for (int i = 0; i < HB + 1; i++) tick();
    reply_valid = 1'b1; reply_dst_id = 8'h05; reply_header = r.sys_header; reply_payload = r.payload;
    checks++; if (reply_ready !== 1'b1) $display("FAIL prio_reply_ready: got %b want 1", reply_ready); else passed++;
    tick();
    reply_valid = 1'b0;
    exp = flit_t'(exp_q.pop_front());
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== exp) $display("FAIL prio_reply_first: got v=%b %h want v=1 %h", flit_out_valid, flit_out, exp); else passed++;
    tick();
    checks++; if (flit_out_valid !== 1'b0) $display("FAIL prio_gap: got %b want 0", flit_out_valid); else passed++;
    tick();
    exp = flit_t'(exp_q.pop_front());
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== exp) $display("FAIL prio_hb_next: got v=%b %h want v=1 %h", flit_out_valid, flit_out, exp); else passed++;
  endtask

  task automatic test_state_change_drop();
    flit_t r, exp;
    r = '0;
    r.header.flittype = SYSTEM; r.header.src_id = NODE; r.header.dst_id = 8'h07;
    r.sys_header.sys_type = S_PARENT_ACK; r.payload.child_id = 8'h07;
    exp = mk_flit(S_PARENT_REQUEST, BROADCAST_NODE_ID, 8'h00, 1'b0);
    tick();
    flit_out_ready = 1'b0;
    reply_valid = 1'b1; reply_dst_id = 8'h07; reply_header = r.sys_header; reply_payload = r.payload;
    tick();
    reply_valid = 1'b0;
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== r) $display("FAIL drop_reply: got v=%b %h want v=1 %h", flit_out_valid, flit_out, r); else passed++;
    for (int i = 0; i < 18; i++) tick();
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== r) $display("FAIL drop_reply_stall: got v=%b %h want v=1 %h", flit_out_valid, flit_out, r); else passed++;
    routing_state = S_WAIT_PARENT_ACK;
    flit_out_ready = 1'b1;
    tick();
    checks++; if (flit_out_valid !== 1'b0) $display("FAIL drop_gap: got %b want 0", flit_out_valid); else passed++;
    tick();
    checks++; if (flit_out_valid !== 1'b1 || flit_out !== exp) $display("FAIL drop_new_state_flit: got v=%b %h want v=1 %h", flit_out_valid, flit_out, exp); else passed++;
  endtask

  task automatic test_reset_midflight();
    int vcnt, ucnt;
    flit_out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (flit_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", flit_out_valid); else passed++;
    checks++; if (flit_out !== flit_t'('0)) $display("FAIL midrst_flit: got %h want 0", flit_out); else passed++;
    checks++; if (update_next_state !== 1'b0) $display("FAIL midrst_upd: got %b want 0", update_next_state); else passed++;
    routing_state = FATAL_ERROR;
    tick();
    rst_n = 1'b1; flit_out_ready = 1'b1;
    vcnt = 0; ucnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (flit_out_valid) vcnt++;
      if (update_next_state) ucnt++;
    end
    checks++; if (vcnt + ucnt != 0) $display("FAIL midrst_quiet: got %0d flits %0d pulses want 0", vcnt, ucnt); else passed++;
  endtask

  task automatic test_root();
    checks++; if (root_valid_seen != 0) $display("FAIL root_no_flits: got %0d want 0", root_valid_seen); else passed++;
    checks++; if (root_upd_seen != 0) $display("FAIL root_no_pulses: got %0d want 0", root_upd_seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_parent_request();
    test_join_stall();
    test_heartbeat();
    test_reply_priority();
    test_state_change_drop();
    test_reset_midflight();
    test_root();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/system_flit_generator.md
# system_flit_generator

Transmit-side counterpart of the router's system-flit decode path: builds and emits SYSTEM flits for the routing/join protocol. Self-generated traffic covers parent-request broadcasts, join requests, periodic retries and heartbeats. It also emits replies requested by the decode path (parent ack, join ack, forwarded join request). It sits in the router between the routing-state register/decoder and the output flit arbiter. It owns the retry and heartbeat timers and requests the routing-state transitions that follow successful transmission or timeout.

## Interface
- IS_ROOT, 0, node is tree root: no parent requests, join requests or heartbeats
- RETRY_CYCLES, 1024, cycles between request retransmissions in WAIT states (≥2)
- MAX_RETRIES, 8, retransmissions before FATAL_ERROR (≥1)
- HEARTBEAT_CYCLES, 4096, heartbeat period in NORMAL (≥2)

Ports:
- nocclk  in  1  clock; only clock
- rst_n  in  1  reset, synchronous, active-low
- routing_state  in  system_types::routing_state_t  current routing state
- this_node_id  in  types::node_id_t  own id (src_id of every flit)
- parent_id  in  types::node_id_t  current parent
- reply_valid  in  1  decode path requests a reply flit
- reply_ready  out  1  reply accepted this cycle when both high
- reply_header  in  system_types::system_header_t  reply system header
- reply_payload  in  system_types::system_payload_t  reply payload
- reply_dst_id  in  types::node_id_t  reply destination
- flit_out  out  types::flit_t  generated flit
- flit_out_valid  out  1  flit_out valid
- flit_out_ready  in  1  downstream accepts
- update_next_state  out  1  one-cycle request to change routing state
- next_routing_state  out  system_types::routing_state_t  target state; FATAL_ERROR when not requesting

## Operation
- Every flit: header.flittype=SYSTEM, header.src_id=this_node_id; is_init field=1 in I_* states, 0 otherwise.
- Output FSM: G_IDLE, G_SEND. G_IDLE loads flit_out, goes G_SEND; G_SEND holds until flit_out_valid&&flit_out_ready, then G_IDLE.
- Load priority in G_IDLE: reply (reply_ready=1 only in G_IDLE) > pending self flit. Reply is copied verbatim.
- Self flits (IS_ROOT=0 only):
  - I/S_WAIT_PARENT_ACK: S_PARENT_REQUEST to system_types::BROADCAST_NODE_ID, on state entry and on each retry expiry.
  - I/S_GENERATE_JOIN_REQUEST: S_JOIN_REQUEST, dst=parent_id, child_id=this_node_id, once on entry. On its handshake: update_next_state=1, next_routing_state=matching I/S_WAIT_JOIN_ACK.
  - I/S_WAIT_JOIN_ACK: retry expiry resends S_JOIN_REQUEST.
  - NORMAL: S_HEARTBEAT to parent_id every HEARTBEAT_CYCLES.
- Retry counter: cleared on state entry; +1 per retransmission. Expiry with count==MAX_RETRIES emits no flit; it pulses update_next_state with FATAL_ERROR.
- FATAL_ERROR and unlisted states: no self flits; replies still served.

## Timing
- Reset (rst_n=0 at edge): G_IDLE, flit_out_valid=0, flit_out=0, update_next_state=0, next_routing_state=FATAL_ERROR, timers/counter/pending=0. reply_ready=0 while rst_n=0.
- Reply accepted cycle N → flit_out_valid=1 cycle N+1 (registered). Minimum 2 cycles per flit.
- flit_out stable while valid&&!ready.
- State entry = routing_state differs from previous-cycle registered copy. Entry sets self-pending in the same cycle; earliest self flit valid at N+1.
- Timer: reloads to 0 on entry and on each self-flit handshake. Counts only while no self flit pending/in flight. Expires when value==period-1, setting pending next cycle.
- State change with self flit pending but not loaded: drop it. Already in G_SEND: complete it, no state-update pulse unless still in the GENERATE state.
- Reply and self-pending together: reply wins; self stays pending.
- update_next_state is a registered one-cycle pulse, the cycle after the qualifying handshake/expiry.

## Structure
- system_types: add BROADCAST_NODE_ID and gen_state_t {G_IDLE, G_SEND}.
- Sub-module system_flit_retry_timer (params PERIOD; ports nocclk, rst_n, clear, enable, expire). Instantiated twice: retry and heartbeat.

## Test plan
- Reset, routing_state=I_WAIT_PARENT_ACK, ready=1 → PARENT_REQUEST to BROADCAST_NODE_ID, is_init=1, at cycle 1. Repeats every RETRY_CYCLES. After 8 retries → update_next_state pulse, FATAL_ERROR.
- I_GENERATE_JOIN_REQUEST, parent_id=0x10, this_node_id=0x23, ready held 0 for 5 cycles → flit_out stable. On accept: pulse to I_WAIT_JOIN_ACK.
- reply_valid with S_JOIN_ACK dst 0x05 concurrent with pending heartbeat → JOIN_ACK emitted first, heartbeat next.
- NORMAL, HEARTBEAT_CYCLES=16 → HEARTBEAT to parent every 16 cycles. IS_ROOT=1 → none.
- rst_n low while flit_out_valid=1 → valid 0 after edge; no flit, no pulse.
- routing_state change with self flit pending → flit dropped; new state's flit emitted.
